// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port and RAM-controller command port.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_cack;
  logic        if_ready;
  logic        if_busy;
  logic [31:0] if_data;

  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_cack;
  logic        dm_ready;
  logic        dm_busy;
  logic [15:0] dm_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_cack;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_cack, if_ready, if_busy, if_data,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_cack, dm_ready, dm_busy, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_cack, mem_ready, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_cack, if_ready, if_busy, if_data,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_cack, dm_ready, dm_busy, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_cack, mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port RAM arbiter: instruction fetch and data unit share one RAM controller.
// Data port wins ties, except fetch is forced through after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_r;
  state_t      state_nxt;
  owner_t      owner_r;
  logic [3:0]  starve_r;

  logic        grant_if_s;
  logic        grant_dm_s;
  logic        complete_s;

  logic        mem_req_r;
  logic        mem_we_r;
  logic [15:0] mem_addr_r;
  logic [15:0] mem_wdata_r;
  logic        if_ready_r;
  logic        dm_ready_r;
  logic [31:0] if_data_r;
  logic [15:0] dm_rdata_r;

  // Arbitration is only live in IDLE; outside it no grant can be made.
  always_comb begin
    grant_dm_s = 1'b0;
    grant_if_s = 1'b0;
    if (state_r == ST_IDLE) begin
      grant_dm_s = bus.dm_req && (!bus.if_req || (starve_r != LIMIT));
      grant_if_s = bus.if_req && !grant_dm_s;
    end else begin
      grant_dm_s = 1'b0;
      grant_if_s = 1'b0;
    end
  end

  // Next-state logic; cack together with ready in ISSUE completes immediately.
  always_comb begin
    state_nxt  = state_r;
    complete_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_if_s || grant_dm_s) begin
          state_nxt = ST_ISSUE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_cack && bus.mem_ready) begin
          complete_s = 1'b1;
          state_nxt  = ST_IDLE;
        end else if (bus.mem_cack) begin
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (bus.mem_ready) begin
          complete_s = 1'b1;
          state_nxt  = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Owner and starvation counter; the counter only counts data grants that made fetch wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r  <= OWN_IF;
      starve_r <= 4'd0;
    end else if (grant_dm_s) begin
      owner_r <= OWN_DM;
      if (bus.if_req && (starve_r < LIMIT)) begin
        starve_r <= starve_r + 4'd1;
      end
    end else if (grant_if_s) begin
      owner_r  <= OWN_IF;
      starve_r <= 4'd0;
    end
  end

  // Command register toward the RAM controller; held stable for the whole ISSUE phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 16'h0000;
      mem_wdata_r <= 16'h0000;
    end else begin
      mem_req_r <= (state_nxt == ST_ISSUE);
      if (grant_dm_s) begin
        mem_we_r    <= bus.dm_we;
        mem_addr_r  <= bus.dm_addr;
        mem_wdata_r <= bus.dm_wdata;
      end else if (grant_if_s) begin
        mem_we_r    <= 1'b0;
        mem_addr_r  <= bus.if_addr;
        mem_wdata_r <= 16'h0000;
      end
    end
  end

  // Completion: latch read data for the owner and pulse its ready for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_ready_r <= 1'b0;
      dm_ready_r <= 1'b0;
      if_data_r  <= 32'h0000_0000;
      dm_rdata_r <= 16'h0000;
    end else begin
      if_ready_r <= complete_s && (owner_r == OWN_IF);
      dm_ready_r <= complete_s && (owner_r == OWN_DM);
      if (complete_s && (owner_r == OWN_IF)) begin
        if_data_r <= bus.mem_rdata;
      end
      if (complete_s && (owner_r == OWN_DM)) begin
        dm_rdata_r <= bus.mem_rdata[15:0];
      end
    end
  end

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.if_ready  = if_ready_r;
  assign bus.dm_ready  = dm_ready_r;
  assign bus.if_data   = if_data_r;
  assign bus.dm_rdata  = dm_rdata_r;

  // Accept strobes pass mem_cack straight through to the port that owns the command.
  assign bus.if_cack = bus.mem_cack && (state_r == ST_ISSUE) && (owner_r == OWN_IF);
  assign bus.dm_cack = bus.mem_cack && (state_r == ST_ISSUE) && (owner_r == OWN_DM);

  assign bus.if_busy = ((state_r != ST_IDLE) && (owner_r == OWN_DM)) || grant_dm_s;
  assign bus.dm_busy = ((state_r != ST_IDLE) && (owner_r == OWN_IF)) || grant_if_s;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4 (legal 1..15): max consecutive data-port grants while fetch waits.
REQ-002 SHALL have ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch read request, level, held until if_cack
- if_addr  in  16  fetch word address
- if_cack  out  1  fetch command accepted by RAM
- if_ready  out  1  one-cycle pulse, if_data valid
- if_busy  out  1  port unavailable to fetch
- if_data  out  32  fetched instruction
- dm_req  in  1  data request, level, held until dm_cack
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  16  data word address
- dm_wdata  in  16  write data
- dm_cack  out  1  data command accepted
- dm_ready  out  1  one-cycle pulse, read data valid or write done
- dm_busy  out  1  port unavailable to data unit
- dm_rdata  out  16  read data, mem_rdata[15:0]
- mem_req  out  1  command to RAM controller
- mem_we  out  1  command is write
- mem_addr  out  16  command address
- mem_wdata  out  16  command write data
- mem_cack  in  1  RAM registered command
- mem_ready  in  1  RAM transaction complete
- mem_rdata  in  32  RAM read data

Function
REQ-003 SHALL implement FSM: IDLE, ISSUE (mem_req high, awaiting mem_cack), WAIT (awaiting mem_ready), plus owner register (IF/DM).
REQ-004 In IDLE, SHALL arbitrate on rising edge: only one request -> grant it; both -> DM, unless starve counter == STARVE_LIMIT, then IF.
REQ-005 On grant SHALL register mem_addr/mem_we/mem_wdata from the owner (mem_we=0, mem_wdata=0 for IF), set mem_req=1, enter ISSUE; mem_req visible the cycle after the request is sampled.
REQ-006 In ISSUE, mem_cack=0 -> stay, mem_req and command held stable; mem_cack=1 -> mem_req=0, enter WAIT.
REQ-007 mem_cack and mem_ready high in the same ISSUE cycle SHALL be treated as completion: skip WAIT, perform REQ-008.
REQ-008 On mem_ready in WAIT SHALL latch mem_rdata into owner's data output, pulse owner's *_ready for exactly one cycle, return to IDLE; non-owner *_ready stays 0.
REQ-009 if_data/dm_rdata SHALL hold last latched value until the next completion for that port.
REQ-010 *_cack SHALL equal mem_cack gated by (state==ISSUE and owner matches), combinational.
REQ-011 if_busy SHALL be 1 when state!=IDLE and owner==DM, or state==IDLE and dm_req wins REQ-004; dm_busy symmetric.
REQ-012 Starve counter (4 bits) SHALL increment on each DM grant made while if_req=1, clear on each IF grant, saturate at STARVE_LIMIT.
REQ-013 Requester deasserting *_req after its grant SHALL NOT cancel the transaction; it completes and ready pulses.
REQ-014 mem_ready outside WAIT/ISSUE SHALL be ignored.
REQ-015 Minimum one IDLE cycle between transactions; back-to-back single-port throughput = 1 transaction per (latency + 2) cycles.

Reset
REQ-016 rst=1 SHALL immediately force state=IDLE, owner=IF, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_data=0, dm_rdata=0, all ready/cack=0.
REQ-017 Reset mid-transaction SHALL discard it; no ready pulse after release; first post-reset request arbitrated fresh.

Verification
REQ-018 Single fetch: if_req, if_addr=0x0010, mem_cack one cycle after mem_req, mem_ready 2 cycles later with 0xDEADBEEF -> if_ready 1-cycle pulse, if_data=0xDEADBEEF, dm_ready stays 0.
REQ-019 Simultaneous: if_req and dm_req (write 0x1234 to 0x0200) same cycle -> mem_we=1, mem_addr=0x0200 first; fetch served next; if_busy=1 during DM transaction.
REQ-020 Starvation: dm_req and if_req held continuously, STARVE_LIMIT=4 -> grant order DM,DM,DM,DM,IF,DM...
REQ-021 Retry: mem_cack withheld 5 cycles -> mem_req and mem_addr stable all 5 cycles; mem_cack+mem_ready same cycle -> ready pulse, IDLE next.
REQ-022 Reset in WAIT: rst pulsed, then mem_ready -> no ready pulse, all outputs at reset values, next if_req served normally.
